// File: rtl/ook_burst_modulator.sv
// On-off-keyed burst modulator: sends a preamble followed by a captured
// payload word, MSB first, gating a divided square-wave carrier onto the
// probe pin during '1' bits. Supports continuous repeat, abort and a
// busy/done handshake.
module ook_burst_modulator #(
    parameter int                    DATA_W      = 128,
    parameter int                    PREAMBLE_W  = 8,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE    = 8'hA5,
    parameter int                    BIT_CYCLES  = 1024,
    parameter int                    CARRIER_DIV = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [DATA_W-1:0]                      data,
    input  logic                                   loop_en,
    input  logic                                   abort,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   tx_bit,
    output logic [$clog2(PREAMBLE_W+DATA_W)-1:0]   bit_idx,
    output logic                                   carrier_out
);

    localparam int FRAME_W = PREAMBLE_W + DATA_W;
    localparam int IDX_W   = $clog2(FRAME_W);
    localparam int CYC_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int PH_W    = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    state_t                state, state_nxt;
    logic [DATA_W-1:0]     cap_reg, cap_nxt;
    logic [DATA_W-1:0]     data_sr, data_sr_nxt;
    logic [PREAMBLE_W-1:0] pre_sr, pre_sr_nxt;
    logic [CYC_W-1:0]      cyc_cnt, cyc_nxt;
    logic [IDX_W-1:0]      bit_cnt, bit_nxt;
    logic [PH_W-1:0]       phase_cnt, phase_nxt;
    logic                  carrier_q, carrier_q_nxt;
    logic                  done_nxt;
    logic                  tx_bit_nxt;
    logic                  carrier_out_nxt;
    logic                  bit_end;

    // Next-state logic for the FSM and the whole datapath; abort wins over
    // both the start request and the loop reload.
    always_comb begin
        state_nxt     = state;
        cap_nxt       = cap_reg;
        data_sr_nxt   = data_sr;
        pre_sr_nxt    = pre_sr;
        cyc_nxt       = cyc_cnt;
        bit_nxt       = bit_cnt;
        phase_nxt     = phase_cnt;
        carrier_q_nxt = carrier_q;
        done_nxt      = 1'b0;
        bit_end       = (cyc_cnt == CYC_W'(BIT_CYCLES - 1));

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt     = PRE;
                    cap_nxt       = data;
                    data_sr_nxt   = data;
                    pre_sr_nxt    = PREAMBLE;
                    cyc_nxt       = '0;
                    bit_nxt       = '0;
                    phase_nxt     = '0;
                    carrier_q_nxt = 1'b0;
                end
            end
            PRE, DATA: begin
                if (abort) begin
                    state_nxt     = IDLE;
                    cyc_nxt       = '0;
                    bit_nxt       = '0;
                    phase_nxt     = '0;
                    carrier_q_nxt = 1'b0;
                end else begin
                    if (phase_cnt == PH_W'(CARRIER_DIV - 1)) begin
                        phase_nxt     = '0;
                        carrier_q_nxt = ~carrier_q;
                    end else begin
                        phase_nxt = phase_cnt + PH_W'(1);
                    end

                    if (bit_end) begin
                        cyc_nxt = '0;
                        bit_nxt = bit_cnt + IDX_W'(1);
                        if (state == PRE) begin
                            pre_sr_nxt = pre_sr << 1;
                            if (bit_cnt == IDX_W'(PREAMBLE_W - 1)) begin
                                state_nxt = DATA;
                            end
                        end else begin
                            data_sr_nxt = data_sr << 1;
                            if (bit_cnt == IDX_W'(FRAME_W - 1)) begin
                                done_nxt      = 1'b1;
                                bit_nxt       = '0;
                                phase_nxt     = '0;
                                carrier_q_nxt = 1'b0;
                                if (loop_en) begin
                                    state_nxt   = PRE;
                                    data_sr_nxt = cap_reg;
                                    pre_sr_nxt  = PREAMBLE;
                                end else begin
                                    state_nxt = IDLE;
                                end
                            end
                        end
                    end else begin
                        cyc_nxt = cyc_cnt + CYC_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        case (state_nxt)
            PRE:     tx_bit_nxt = pre_sr_nxt[PREAMBLE_W-1];
            DATA:    tx_bit_nxt = data_sr_nxt[DATA_W-1];
            default: tx_bit_nxt = 1'b0;
        endcase
        carrier_out_nxt = carrier_q_nxt & tx_bit_nxt & (state_nxt != IDLE);
    end

    // State and datapath registers; the output carrier is registered from
    // the next-cycle values so it matches carrier_q & tx_bit & busy glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cap_reg     <= '0;
            data_sr     <= '0;
            pre_sr      <= '0;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            phase_cnt   <= '0;
            carrier_q   <= 1'b0;
            done        <= 1'b0;
            carrier_out <= 1'b0;
        end else begin
            state       <= state_nxt;
            cap_reg     <= cap_nxt;
            data_sr     <= data_sr_nxt;
            pre_sr      <= pre_sr_nxt;
            cyc_cnt     <= cyc_nxt;
            bit_cnt     <= bit_nxt;
            phase_cnt   <= phase_nxt;
            carrier_q   <= carrier_q_nxt;
            done        <= done_nxt;
            carrier_out <= carrier_out_nxt;
        end
    end

    // Status outputs decoded straight from registered state.
    always_comb begin
        busy    = (state != IDLE);
        bit_idx = bit_cnt;
        case (state)
            PRE:     tx_bit = pre_sr[PREAMBLE_W-1];
            DATA:    tx_bit = data_sr[DATA_W-1];
            default: tx_bit = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ook_burst_modulator.sv
// Scoreboard bench for ook_burst_modulator: per-cycle expected output words
// are queued when a frame is requested and compared cycle by cycle.
module tb_ook_burst_modulator;

    localparam int DATA_W      = 8;
    localparam int PREAMBLE_W  = 4;
    localparam int BIT_CYCLES  = 4;
    localparam int CARRIER_DIV = 1;
    localparam int FRAME_W     = PREAMBLE_W + DATA_W;
    localparam int IDX_W       = $clog2(FRAME_W);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] data;
    logic              loop_en;
    logic              abort;
    logic              busy;
    logic              done;
    logic              tx_bit;
    logic [IDX_W-1:0]  bit_idx;
    logic              carrier_out;

    int                tests = 0;
    int                errors = 0;
    int                cyc = 0;
    string             phase = "init";
    logic [15:0]       sb[$];

    ook_burst_modulator #(
        .DATA_W(DATA_W),
        .PREAMBLE_W(PREAMBLE_W),
        .PREAMBLE(4'hA),
        .BIT_CYCLES(BIT_CYCLES),
        .CARRIER_DIV(CARRIER_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .data(data),
        .loop_en(loop_en),
        .abort(abort),
        .busy(busy),
        .done(done),
        .tx_bit(tx_bit),
        .bit_idx(bit_idx),
        .carrier_out(carrier_out)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] observed();
        return {busy, done, tx_bit, carrier_out, bit_idx};
    endfunction

    // Expected word layout: {busy, done, tx_bit, carrier_out, bit_idx}; the
    // upper byte of each queue entry is a compare mask.
    function automatic void pushFrame(input logic [DATA_W-1:0] d, input bit done_first, input int ncyc);
        logic [FRAME_W-1:0] frame;
        logic               bitv;
        logic               car;
        int                 b;
        frame = {4'hA, d};
        for (int c = 0; c < ncyc; c++) begin
            b    = c / BIT_CYCLES;
            bitv = frame[FRAME_W-1-b];
            car  = bitv & ((c % 2) == 1);
            sb.push_back({8'hFF, 1'b1, (done_first && c == 0), bitv, car, 4'(b)});
        end
    endfunction

    function automatic void pushDone();
        sb.push_back({8'hF0, 8'b0100_0000});
    endfunction

    function automatic void pushIdle(input int n);
        for (int i = 0; i < n; i++) sb.push_back({8'hF0, 8'h00});
    endfunction

    task automatic stepCycle();
        logic [15:0] e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput($sformatf("%s[%0d]", phase, cyc), {24'b0, observed() & e[15:8]}, {24'b0, e[7:0]});
        end
        cyc++;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic drain();
        while (sb.size() > 0) stepCycle();
    endtask

    task automatic applyStimulus(input string name, input logic [DATA_W-1:0] d, input logic lp, input int ncyc);
        phase   = name;
        cyc     = 0;
        data    = d;
        loop_en = lp;
        start   = 1'b1;
        pushFrame(d, 1'b0, ncyc);
        stepCycle();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data = '0; loop_en = 1'b0; abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", {24'b0, observed()}, 32'h0);
        rst = 1'b0;

        phase = "idle"; cyc = 0;
        pushIdle(20);
        drain();

        applyStimulus("frame_c3", 8'hC3, 1'b0, 48);
        pushDone();
        pushIdle(3);
        drain();

        applyStimulus("busy_start", 8'h5A, 1'b0, 48);
        pushDone();
        pushIdle(2);
        stepN(10);
        start = 1'b1; data = 8'h3C;
        stepCycle();
        start = 1'b0;
        drain();

        applyStimulus("loop_ff", 8'hFF, 1'b1, 48);
        pushFrame(8'hFF, 1'b1, 48);
        pushDone();
        pushIdle(2);
        stepN(19);
        data = 8'h00;
        stepN(40);
        loop_en = 1'b0;
        drain();

        applyStimulus("abort", 8'hC3, 1'b0, 21);
        stepN(20);
        abort = 1'b1;
        pushIdle(3);
        stepCycle();
        abort = 1'b0;
        drain();

        phase = "start_abort"; cyc = 0;
        start = 1'b1; abort = 1'b1; data = 8'hFF;
        pushIdle(4);
        stepCycle();
        start = 1'b0; abort = 1'b0;
        drain();

        applyStimulus("async_rst", 8'hC3, 1'b0, 31);
        stepN(30);
        #1 rst = 1'b1;
        #1 checkOutput("async_rst_out", {24'b0, observed()}, 32'h0);
        #1 rst = 1'b0;
        pushIdle(2);
        drain();

        applyStimulus("post_rst", 8'hA5, 1'b0, 48);
        pushDone();
        pushIdle(2);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
